// File: rtl/lv_efuse_pkg.sv
// Shared types and constants for the LV eFuse loader.
package lv_efuse_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StRead,
        StCapt,
        StCheck,
        StDone,
        StRelease
    } efuse_ld_st_e;

    localparam logic [7:0]  Crc8Poly        = 8'h07;
    localparam logic [7:0]  Crc8Init        = 8'h00;
    localparam int unsigned EfuseWordNumDef = 8;
    localparam int unsigned EfuseDataWDef   = 8;

endpackage

// File: rtl/lv_efuse_crc8.sv
// Combinational CRC-8 step (poly 0x07, MSB first) over one eFuse word.
import lv_efuse_pkg::*;

module lv_efuse_crc8 #(
    parameter int unsigned DATA_W = EfuseDataWDef
) (
    input  logic [7:0]        crc_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [7:0]        crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            if (crc_out[7] ^ data_in[i]) begin
                crc_out = {crc_out[6:0], 1'b0} ^ Crc8Poly;
            end else begin
                crc_out = {crc_out[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/lv_efuse_loader.sv
// eFuse load responder: timed word reads, register-bank writes, checksum check.
// Define LV_EFUSE_CRC_EN to use a CRC-8 accumulator instead of XOR.
import lv_efuse_pkg::*;

module lv_efuse_loader #(
    parameter int unsigned EFUSE_WORD_NUM = EfuseWordNumDef,
    parameter int unsigned EFUSE_ADDR_W   = 3,
    parameter int unsigned EFUSE_DATA_W   = EfuseDataWDef,
    parameter int unsigned RD_WAIT_CYC    = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_efuse_load_req,
    output logic                    o_efuse_load_done,
    output logic                    o_efuse_vld,
    output logic                    o_efuse_busy,
    output logic                    o_efuse_csb,
    output logic                    o_efuse_rden,
    output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
    input  logic [EFUSE_DATA_W-1:0] i_efuse_rdata,
    output logic                    o_efuse_reg_wen,
    output logic [EFUSE_ADDR_W-1:0] o_efuse_reg_waddr,
    output logic [EFUSE_DATA_W-1:0] o_efuse_reg_wdata
);

`ifdef LV_EFUSE_CRC_EN
    localparam int unsigned AccW = 8;
    localparam logic [AccW-1:0] AccInit = Crc8Init;
`else
    localparam int unsigned AccW = EFUSE_DATA_W;
    localparam logic [AccW-1:0] AccInit = '0;
`endif

    localparam logic [3:0]              WaitLoad = 4'(RD_WAIT_CYC - 1);
    localparam logic [EFUSE_ADDR_W-1:0] LastIdx  = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

    efuse_ld_st_e            state_q;
    logic [EFUSE_ADDR_W-1:0] idx_q;
    logic [3:0]              wait_q;
    logic [AccW-1:0]         acc_q;
    logic [AccW-1:0]         acc_next;

`ifdef LV_EFUSE_CRC_EN
    lv_efuse_crc8 #(
        .DATA_W (EFUSE_DATA_W)
    ) u_crc8 (
        .crc_in  (acc_q),
        .data_in (i_efuse_rdata),
        .crc_out (acc_next)
    );
`else
    assign acc_next = acc_q ^ i_efuse_rdata;
`endif

    // Outputs are loaded on the same edge as the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q           <= StIdle;
            idx_q             <= '0;
            wait_q            <= '0;
            acc_q             <= AccInit;
            o_efuse_load_done <= 1'b0;
            o_efuse_vld       <= 1'b0;
            o_efuse_busy      <= 1'b0;
            o_efuse_csb       <= 1'b1;
            o_efuse_rden      <= 1'b0;
            o_efuse_addr      <= '0;
            o_efuse_reg_wen   <= 1'b0;
            o_efuse_reg_waddr <= '0;
            o_efuse_reg_wdata <= '0;
        end else begin
            o_efuse_load_done <= 1'b0;
            o_efuse_reg_wen   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_efuse_load_req) begin
                        state_q      <= StSetup;
                        idx_q        <= '0;
                        acc_q        <= AccInit;
                        o_efuse_vld  <= 1'b0;
                        o_efuse_busy <= 1'b1;
                        o_efuse_csb  <= 1'b0;
                        o_efuse_addr <= '0;
                    end
                end
                StSetup: begin
                    state_q      <= StRead;
                    wait_q       <= WaitLoad;
                    o_efuse_rden <= 1'b1;
                end
                StRead: begin
                    if (wait_q == 4'd0) begin
                        state_q      <= StCapt;
                        o_efuse_rden <= 1'b0;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                StCapt: begin
                    o_efuse_reg_wen   <= 1'b1;
                    o_efuse_reg_waddr <= idx_q;
                    o_efuse_reg_wdata <= i_efuse_rdata;
                    if (idx_q == LastIdx) begin
                        // Last word is the checksum; compare it against the finished accumulator.
                        state_q     <= StCheck;
                        o_efuse_vld <= (acc_q == AccW'(i_efuse_rdata));
                        o_efuse_csb <= 1'b1;
                    end else begin
                        state_q      <= StSetup;
                        acc_q        <= acc_next;
                        idx_q        <= idx_q + 1'b1;
                        o_efuse_addr <= idx_q + 1'b1;
                    end
                end
                StCheck: begin
                    state_q           <= StDone;
                    o_efuse_load_done <= 1'b1;
                end
                StDone: begin
                    state_q      <= StRelease;
                    o_efuse_busy <= 1'b0;
                end
                StRelease: begin
                    if (!i_efuse_load_req) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lv_efuse_loader.sv
// Self-checking bench for lv_efuse_loader against a checksum/timing reference model.
`timescale 1ns/1ps

module tb_lv_efuse_loader;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int DoneCyc = 1 + N * (W + 2) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          done;
    logic          vld;
    logic          busy;
    logic          csb;
    logic          rden;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    logic [DW-1:0] img [N];

    int vectors     = 0;
    int miscompares = 0;

    int rden_total = 0;
    int done_total = 0;
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];

    always #5 clk = ~clk;

    // eFuse macro model: data follows the presented address.
    assign rdata = img[addr];

    lv_efuse_loader #(
        .EFUSE_WORD_NUM (N),
        .EFUSE_ADDR_W   (AW),
        .EFUSE_DATA_W   (DW),
        .RD_WAIT_CYC    (W)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_efuse_load_req  (req),
        .o_efuse_load_done (done),
        .o_efuse_vld       (vld),
        .o_efuse_busy      (busy),
        .o_efuse_csb       (csb),
        .o_efuse_rden      (rden),
        .o_efuse_addr      (addr),
        .i_efuse_rdata     (rdata),
        .o_efuse_reg_wen   (wen),
        .o_efuse_reg_waddr (waddr),
        .o_efuse_reg_wdata (wdata)
    );

    always @(negedge clk) begin
        if (rden) rden_total <= rden_total + 1;
        if (done) done_total <= done_total + 1;
        if (wen) begin
            wr_addr_q.push_back(waddr);
            wr_data_q.push_back(wdata);
        end
    end

    function automatic logic [DW-1:0] model_sum();
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < N - 1; k++) begin
`ifdef LV_EFUSE_CRC_EN
            s = s ^ img[k];
            for (int b = 0; b < 8; b++) begin
                if (s[7]) s = (s << 1) ^ 8'h07;
                else      s = s << 1;
            end
`else
            s = s ^ img[k];
`endif
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic make_image(input bit valid);
        for (int k = 0; k < N - 1; k++) img[k] = DW'($urandom_range(0, 255));
        img[N-1] = model_sum();
        if (!valid) img[N-1] = img[N-1] ^ DW'($urandom_range(1, 255));
    endtask

    // Called at a negedge with the FSM idle; the next posedge accepts the request.
    task automatic run_load(input string tag, input int drop_at, input int hold);
        int   wr_base, rd_base, done_base, done_n, bad;
        logic exp_vld;
        exp_vld   = (model_sum() == img[N-1]);
        wr_base   = wr_addr_q.size();
        rd_base   = rden_total;
        done_base = done_total;
        done_n    = 0;
        req       = 1'b1;
        for (int n = 1; n <= DoneCyc + 20 && done_n == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check({tag, "_busy_start"}, 32'(busy), 32'd1);
                check({tag, "_vld_cleared"}, 32'(vld), 32'd0);
            end
            if (n == DoneCyc - 2) check({tag, "_vld_pre"}, 32'(vld), 32'd0);
            if (n == DoneCyc - 1) check({tag, "_vld_early"}, 32'(vld), 32'(exp_vld));
            if (n == drop_at) req = 1'b0;
            if (done) done_n = n;
        end
        check({tag, "_done_cycle"}, 32'(done_n), 32'(DoneCyc));
        check({tag, "_vld"}, 32'(vld), 32'(exp_vld));
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (busy || !csb || done) bad++;
        end
        check({tag, "_quiet_after_done"}, 32'(bad), 32'd0);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, 32'(done_total - done_base), 32'd1);
        check({tag, "_rden_cycles"}, 32'(rden_total - rd_base), 32'(N * W));
        check({tag, "_write_count"}, 32'(wr_addr_q.size() - wr_base), 32'(N));
        bad = 0;
        for (int k = 0; k < N; k++) begin
            if (wr_base + k < wr_addr_q.size()) begin
                if (wr_addr_q[wr_base + k] !== AW'(k) || wr_data_q[wr_base + k] !== img[k]) bad++;
            end
        end
        check({tag, "_write_data"}, 32'(bad), 32'd0);
        check({tag, "_vld_hold"}, 32'(vld), 32'(exp_vld));
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        for (int k = 0; k < N; k++) img[k] = '0;
        repeat (3) @(negedge clk);
        check("rst_csb", 32'(csb), 32'd1);
        check("rst_rden", 32'(rden), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vld", 32'(vld), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wen", 32'(wen), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < N - 1; k++) img[k] = DW'(k + 1);
        img[N-1] = 8'h00;
        run_load("img_seq", 0, 2);

        img[N-1] = 8'h5A;
        run_load("img_bad", 0, 2);

        for (int k = 0; k < N; k++) img[k] = 8'h00;
        run_load("img_zero", 0, 2);
        img[N-1] = 8'h01;
        run_load("img_zero_bad", 0, 2);

        make_image(1'b1);
        run_load("held", 0, 20);
        make_image(1'b1);
        run_load("after_held", 0, 2);

        make_image(1'b0);
        run_load("drop", 10, 2);

        for (int r = 0; r < 6; r++) begin
            make_image(r[0] == 1'b0);
            run_load($sformatf("rand%0d", r), 0, 2);
        end

        // Reset in the middle of a word read.
        begin
            int done_base;
            make_image(1'b1);
            done_base = done_total;
            req = 1'b1;
            repeat (20) @(negedge clk);
            check("mid_rden_before", 32'(rden), 32'd1);
            rst = 1'b1;
            req = 1'b0;
            @(negedge clk);
            check("mid_csb", 32'(csb), 32'd1);
            check("mid_rden", 32'(rden), 32'd0);
            check("mid_busy", 32'(busy), 32'd0);
            check("mid_vld", 32'(vld), 32'd0);
            check("mid_done", 32'(done), 32'd0);
            rst = 1'b0;
            repeat (DoneCyc) @(negedge clk);
            check("mid_no_done", 32'(done_total - done_base), 32'd0);
        end

        make_image(1'b1);
        run_load("post_rst", 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
